// File: rtl/count_chk_pkg.sv
// ============================================================================
// Module      : count_chk_pkg
// Description : Shared state encoding and widths for count_seq_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_chk_pkg;

    localparam int STATE_W  = 2;
    localparam int STREAK_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_seq_checker.sv
// ============================================================================
// Module      : count_seq_checker
// Description : Tracks a free-running up-count bus, locks on, flags breaks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a,
    input  logic                  en,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]      exp,
    output logic [STATE_W-1:0]    state
);

    state_t              cur_state;
    logic [STREAK_W-1:0] streak;
    logic                match;
    logic                err_inc;
    logic                streak_done;

    assign match       = (a == exp);
    assign streak_done = ((streak + STREAK_W'(1)) == STREAK_W'(LOCK_CNT));
    // Error counter steps on the same edge that raises the err pulse.
    assign err_inc     = en && (cur_state == ST_LOCKED) && !match;
    assign state       = cur_state;

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (1'b0),
        .count (err_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= ST_IDLE;
            locked     <= 1'b0;
            err        <= 1'b0;
            wrap_count <= '0;
            exp        <= '0;
            streak     <= '0;
        end else begin
            err <= 1'b0;
            if (en) begin
                // Prediction always re-seeds from what was actually seen.
                exp <= a + 1'b1;
                case (cur_state)
                    ST_IDLE: begin
                        cur_state <= ST_ACQUIRE;
                        streak    <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (match) begin
                            streak <= streak + STREAK_W'(1);
                            if (streak_done) begin
                                cur_state <= ST_LOCKED;
                                locked    <= 1'b1;
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            if (a == '0) begin
                                wrap_count <= wrap_count + WRAP_CNT_W'(1);
                            end
                        end else begin
                            err       <= 1'b1;
                            cur_state <= ST_ACQUIRE;
                            streak    <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        cur_state <= ST_IDLE;
                        streak    <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// Module      : tb_count_seq_checker
// Description : Directed vector bench for count_seq_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic       en;

    logic       locked,  err;
    logic [7:0] err_count, wrap_count;
    logic [3:0] exp;
    logic [1:0] state;

    logic       locked2, err2;
    logic [1:0] err_count2;
    logic [7:0] wrap_count2;
    logic [3:0] exp2;
    logic [1:0] state2;

    int checks   = 0;
    int failures = 0;

    count_seq_checker #(
        .WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(8), .WRAP_CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .en(en),
        .locked(locked), .err(err), .err_count(err_count),
        .wrap_count(wrap_count), .exp(exp), .state(state)
    );

    count_seq_checker #(
        .WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(2), .WRAP_CNT_W(8)
    ) dut_sat (
        .clk(clk), .rst(rst), .a(a), .en(en),
        .locked(locked2), .err(err2), .err_count(err_count2),
        .wrap_count(wrap_count2), .exp(exp2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] a;
        logic       locked;
        logic       err;
        logic [1:0] state;
        logic [3:0] exp;
        logic [7:0] err_count;
        logic [7:0] wrap_count;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic step(input logic e, input logic [3:0] v);
        @(negedge clk);
        en = e;
        a  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        a   = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int pulses_sat;
        logic [3:0] x;
        logic [3:0] model_exp;

        //            en  a      lck err st exp  ecnt wcnt
        vecs[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 2'd1, 4'd1,  8'd0, 8'd0};
        vecs[1]  = '{1'b1, 4'd1,  1'b0, 1'b0, 2'd1, 4'd2,  8'd0, 8'd0};
        vecs[2]  = '{1'b1, 4'd2,  1'b1, 1'b0, 2'd2, 4'd3,  8'd0, 8'd0};
        vecs[3]  = '{1'b1, 4'd3,  1'b1, 1'b0, 2'd2, 4'd4,  8'd0, 8'd0};
        vecs[4]  = '{1'b1, 4'd4,  1'b1, 1'b0, 2'd2, 4'd5,  8'd0, 8'd0};
        vecs[5]  = '{1'b1, 4'd5,  1'b1, 1'b0, 2'd2, 4'd6,  8'd0, 8'd0};
        vecs[6]  = '{1'b1, 4'd6,  1'b1, 1'b0, 2'd2, 4'd7,  8'd0, 8'd0};
        vecs[7]  = '{1'b1, 4'd9,  1'b0, 1'b1, 2'd1, 4'd10, 8'd1, 8'd0};
        vecs[8]  = '{1'b1, 4'd10, 1'b0, 1'b0, 2'd1, 4'd11, 8'd1, 8'd0};
        vecs[9]  = '{1'b1, 4'd11, 1'b1, 1'b0, 2'd2, 4'd12, 8'd1, 8'd0};
        vecs[10] = '{1'b0, 4'd7,  1'b1, 1'b0, 2'd2, 4'd12, 8'd1, 8'd0};
        vecs[11] = '{1'b0, 4'd12, 1'b1, 1'b0, 2'd2, 4'd12, 8'd1, 8'd0};
        vecs[12] = '{1'b1, 4'd12, 1'b1, 1'b0, 2'd2, 4'd13, 8'd1, 8'd0};
        vecs[13] = '{1'b1, 4'd13, 1'b1, 1'b0, 2'd2, 4'd14, 8'd1, 8'd0};
        vecs[14] = '{1'b1, 4'd13, 1'b0, 1'b1, 2'd1, 4'd14, 8'd2, 8'd0};
        vecs[15] = '{1'b1, 4'd14, 1'b0, 1'b0, 2'd1, 4'd15, 8'd2, 8'd0};
        vecs[16] = '{1'b1, 4'd15, 1'b1, 1'b0, 2'd2, 4'd0,  8'd2, 8'd0};
        vecs[17] = '{1'b1, 4'd0,  1'b1, 1'b0, 2'd2, 4'd1,  8'd2, 8'd1};
        vecs[18] = '{1'b1, 4'd5,  1'b0, 1'b1, 2'd1, 4'd6,  8'd3, 8'd1};
        vecs[19] = '{1'b1, 4'd15, 1'b0, 1'b0, 2'd1, 4'd0,  8'd3, 8'd1};
        vecs[20] = '{1'b1, 4'd0,  1'b0, 1'b0, 2'd1, 4'd1,  8'd3, 8'd1};
        vecs[21] = '{1'b1, 4'd1,  1'b1, 1'b0, 2'd2, 4'd2,  8'd3, 8'd1};

        rst = 1'b1;
        en  = 1'b0;
        a   = 4'd0;
        #99;
        chk("reset_state",      32'(state),      32'd0);
        chk("reset_locked",     32'(locked),     32'd0);
        chk("reset_err",        32'(err),        32'd0);
        chk("reset_err_count",  32'(err_count),  32'd0);
        chk("reset_wrap_count", 32'(wrap_count), 32'd0);
        chk("reset_exp",        32'(exp),        32'd0);
        #1;
        rst = 1'b0;

        // Table: lock-on, skip error, en hold, repeat error, locked wrap, acquire wrap.
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].en, vecs[i].a);
            chk($sformatf("vec%0d_locked", i),     32'(locked),     32'(vecs[i].locked));
            chk($sformatf("vec%0d_err", i),        32'(err),        32'(vecs[i].err));
            chk($sformatf("vec%0d_state", i),      32'(state),      32'(vecs[i].state));
            chk($sformatf("vec%0d_exp", i),        32'(exp),        32'(vecs[i].exp));
            chk($sformatf("vec%0d_err_count", i),  32'(err_count),  32'(vecs[i].err_count));
            chk($sformatf("vec%0d_wrap_count", i), 32'(wrap_count), 32'(vecs[i].wrap_count));
        end

        // Long locked run 0..15,0..15,0..7.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'(i));
            if (err) pulses++;
        end
        chk("run_locked",     32'(locked),     32'd1);
        chk("run_wrap_count", 32'(wrap_count), 32'd2);
        chk("run_err_count",  32'(err_count),  32'd0);
        chk("run_exp",        32'(exp),        32'd8);
        chk("run_err_pulses", 32'(pulses),     32'd0);

        // en low for three cycles while the bus keeps moving.
        do_reset();
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        chk("hold_pre_exp", 32'(exp), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'(4 + i));
            chk("hold_err", 32'(err), 32'd0);
            chk("hold_exp", 32'(exp), 32'd4);
        end
        step(1'b1, 4'd4);
        chk("resume_err",    32'(err),    32'd0);
        chk("resume_exp",    32'(exp),    32'd5);
        chk("resume_locked", 32'(locked), 32'd1);

        // Five LOCKED mismatches with relock; narrow counter saturates at 3.
        do_reset();
        step(1'b1, 4'd0);
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        model_exp  = 4'd3;
        pulses     = 0;
        pulses_sat = 0;
        for (int k = 0; k < 5; k++) begin
            x = model_exp + 4'd5;
            step(1'b1, x);
            if (err)  pulses++;
            if (err2) pulses_sat++;
            step(1'b1, x + 4'd1);
            if (err2) pulses_sat++;
            step(1'b1, x + 4'd2);
            if (err2) pulses_sat++;
            chk("sat_relock", 32'(locked2), 32'd1);
            model_exp = x + 4'd3;
        end
        chk("sat_pulses",     32'(pulses_sat), 32'd5);
        chk("sat_err_count",  32'(err_count2), 32'd3);
        chk("wide_pulses",    32'(pulses),     32'd5);
        chk("wide_err_count", 32'(err_count),  32'd5);

        // Asynchronous reset between edges while LOCKED with nonzero counters.
        do_reset();
        step(1'b1, 4'd14);
        step(1'b1, 4'd15);
        step(1'b1, 4'd0);
        for (int i = 1; i < 16; i++) step(1'b1, 4'(i));
        step(1'b1, 4'd0);
        step(1'b1, 4'd5);
        step(1'b1, 4'd6);
        step(1'b1, 4'd7);
        chk("pre_async_locked", 32'(locked),     32'd1);
        chk("pre_async_errc",   32'(err_count),  32'd1);
        chk("pre_async_wrapc",  32'(wrap_count), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_state",      32'(state),      32'd0);
        chk("async_locked",     32'(locked),     32'd0);
        chk("async_err_count",  32'(err_count),  32'd0);
        chk("async_wrap_count", 32'(wrap_count), 32'd0);
        chk("async_exp",        32'(exp),        32'd0);
        #1;
        rst = 1'b0;
        step(1'b1, 4'd9);
        chk("post_async_err",   32'(err),   32'd0);
        chk("post_async_state", 32'(state), 32'd1);
        chk("post_async_exp",   32'(exp),   32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
